// File: rtl/command_fifo_dispatcher.sv
// command_fifo_dispatcher: read-side engine for Command_FIFO.
// The FIFO exports no empty flag, so occupancy is tracked locally from
// accepted writes and issued reads. Read data arrives one cycle after
// fifo_rinc and lands in a 2-entry skid buffer that feeds a valid/ready
// consumer. replay_iter_flag flushes everything and counts iterations.
module command_fifo_dispatcher #(
  parameter  int DEPTH  = 16,
  parameter  int ITER_W = 8,
  parameter  int PKT_W  = 32,
  localparam int OCC_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_wr_acc,
  input  logic              replay_iter_flag,
  output logic              fifo_rinc,
  input  logic [PKT_W-1:0]  fifo_rdata,
  output logic              cmd_valid,
  output logic [PKT_W-1:0]  cmd_data,
  input  logic              cmd_ready,
  output logic [OCC_W-1:0]  fifo_occ,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [1:0]       buf_cnt;
  logic [PKT_W-1:0] buf0, buf1;
  logic             inflight;
  logic             flag_d;
  logic             pop;
  logic [2:0]       slots_used;

  assign cmd_valid = (buf_cnt != 2'd0);
  assign cmd_data  = buf0;
  assign pop       = cmd_valid & cmd_ready;
  assign busy      = (state != S_IDLE);

  // Slots committed after this cycle; a pop this cycle frees one, which
  // is what lets a read issue every cycle while the consumer keeps up.
  assign slots_used = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

  assign fifo_rinc = (fifo_occ != '0) && (slots_used < 3'd2) &&
                     (state != S_FLUSH) && !replay_iter_flag;

  // Occupancy: writes minus reads; a flush zeroes it (FIFO pointers reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              fifo_occ <= '0;
    else if (replay_iter_flag) fifo_occ <= '0;
    else                       fifo_occ <= fifo_occ + OCC_W'(fifo_wr_acc) - OCC_W'(fifo_rinc);
  end

  // One read in flight at most; its data is valid the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= fifo_rinc;
  end

  // Skid buffer: buf0 is the head; capture and pop together keep order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else if (replay_iter_flag) begin
      buf_cnt <= 2'd0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf0 <= fifo_rdata;
          else                 buf1 <= fifo_rdata;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= fifo_rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Iteration counter advances on rising edges of the replay flag only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_d   <= 1'b0;
      iter_cnt <= '0;
    end else begin
      flag_d <= replay_iter_flag;
      if (replay_iter_flag && !flag_d) iter_cnt <= iter_cnt + ITER_W'(1);
    end
  end

  // Next-state: flush overrides everything; RUN drains back to IDLE.
  always_comb begin
    state_nxt = state;
    if (replay_iter_flag) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:  if (fifo_wr_acc) state_nxt = S_RUN;
        S_RUN:   if (fifo_occ == '0 && buf_cnt == 2'd0 && !inflight && !fifo_wr_acc)
                   state_nxt = S_IDLE;
        S_FLUSH: state_nxt = fifo_wr_acc ? S_RUN : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

endmodule

// File: tb/tb_command_fifo_dispatcher.sv
// Bench for command_fifo_dispatcher: the bench plays the Command_FIFO,
// keeps a queue-based model of FIFO contents, the in-flight read and the
// delivered-command buffer, and compares every output every cycle.
module tb_command_fifo_dispatcher;
  localparam int DEPTH  = 16;
  localparam int ITER_W = 8;
  localparam int PKT_W  = 32;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              fifo_wr_acc = 1'b0;
  logic              replay_iter_flag = 1'b0;
  logic              cmd_ready = 1'b0;
  logic [PKT_W-1:0]  fifo_rdata = '0;
  logic              fifo_rinc;
  logic              cmd_valid;
  logic [PKT_W-1:0]  cmd_data;
  logic [OCC_W-1:0]  fifo_occ;
  logic [ITER_W-1:0] iter_cnt;
  logic              busy;

  command_fifo_dispatcher #(.DEPTH(DEPTH), .ITER_W(ITER_W), .PKT_W(PKT_W)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_wr_acc(fifo_wr_acc),
    .replay_iter_flag(replay_iter_flag), .fifo_rinc(fifo_rinc),
    .fifo_rdata(fifo_rdata), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .fifo_occ(fifo_occ), .iter_cnt(iter_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model state
  logic [PKT_W-1:0] m_fifo[$];
  logic [PKT_W-1:0] m_skid[$];
  bit               m_infl = 1'b0;
  logic [PKT_W-1:0] m_infl_data = '0;
  int               m_mode = 0;      // 0 idle, 1 run, 2 flush
  int               m_iter = 0;
  bit               m_prev_flag = 1'b0;

  task automatic model_reset();
    m_fifo.delete();
    m_skid.delete();
    m_infl = 1'b0;
    m_infl_data = '0;
    m_mode = 0;
    m_iter = 0;
    m_prev_flag = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model.
  task automatic step(input bit wr, input bit flag, input bit rdy);
    bit w, pop, rinc, drained;
    int occ, used;
    logic [PKT_W-1:0] d;
    @(negedge clk);
    w = wr && (m_fifo.size() < DEPTH);
    fifo_wr_acc      = w;
    replay_iter_flag = flag;
    cmd_ready        = rdy;
    fifo_rdata       = m_infl ? m_infl_data : '0;
    #1;
    occ  = m_fifo.size();
    pop  = (m_skid.size() != 0) && rdy;
    used = m_skid.size() + (m_infl ? 1 : 0) - (pop ? 1 : 0);
    rinc = (occ != 0) && (used < 2) && (m_mode != 2) && !flag;
    chk("rinc",  64'(fifo_rinc), 64'(rinc));
    chk("valid", 64'(cmd_valid), 64'(m_skid.size() != 0));
    if (m_skid.size() != 0) chk("data", 64'(cmd_data), 64'(m_skid[0]));
    chk("occ",   64'(fifo_occ), 64'(occ));
    chk("occ_le_depth", 64'(fifo_occ <= OCC_W'(DEPTH)), 64'(1));
    chk("iter",  64'(iter_cnt), 64'(m_iter % (1 << ITER_W)));
    chk("busy",  64'(busy), 64'(m_mode != 0));
    if (flag) begin
      if (!m_prev_flag) m_iter++;
      m_fifo.delete();
      m_skid.delete();
      m_infl = 1'b0;
      m_mode = 2;
    end else begin
      drained = (occ == 0) && (m_skid.size() == 0) && !m_infl && !w;
      if (pop) void'(m_skid.pop_front());
      if (m_infl) m_skid.push_back(m_infl_data);
      m_infl = rinc;
      if (rinc) m_infl_data = m_fifo.pop_front();
      if (w) begin
        d = $urandom;
        m_fifo.push_back(d);
      end
      case (m_mode)
        0: if (w) m_mode = 1;
        1: if (drained) m_mode = 0;
        default: m_mode = w ? 1 : 0;
      endcase
    end
    m_prev_flag = flag;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rinc",  64'(fifo_rinc), 64'(0));
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_data",  64'(cmd_data),  64'(0));
    chk("rst_occ",   64'(fifo_occ),  64'(0));
    chk("rst_iter",  64'(iter_cnt),  64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Three commands with the consumer ready
    repeat (3) step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_occ",  64'(fifo_occ), 64'(0));

    // Fill the FIFO with the consumer stalled, then release
    repeat (DEPTH) step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("t2_occ",   64'(fifo_occ), 64'(DEPTH - 2));
    chk("t2_valid", 64'(cmd_valid), 64'(1));
    repeat (DEPTH + 4) step(1'b0, 1'b0, 1'b1);

    // Replay pulse mid-stream
    repeat (6) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_valid", 64'(cmd_valid), 64'(0));
    chk("t4_occ",   64'(fifo_occ),  64'(0));
    chk("t4_iter",  64'(iter_cnt),  64'(1));
    repeat (4) step(1'b0, 1'b0, 1'b1);

    // Replay held three cycles, write in the final high cycle and after
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t5_occ",  64'(fifo_occ), 64'(1));
    chk("t5_iter", 64'(iter_cnt), 64'(2));
    repeat (6) step(1'b0, 1'b0, 1'b1);

    // Random traffic
    repeat (800) step($urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 1) == 1);
    repeat (DEPTH + 6) step(1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges
    repeat (10) step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    fifo_wr_acc = 1'b0;
    replay_iter_flag = 1'b0;
    cmd_ready = 1'b0;
    fifo_rdata = '0;
    reset_n = 1'b0;
    #1;
    chk("t6_valid", 64'(cmd_valid), 64'(0));
    chk("t6_rinc",  64'(fifo_rinc), 64'(0));
    chk("t6_occ",   64'(fifo_occ),  64'(0));
    chk("t6_busy",  64'(busy),      64'(0));
    chk("t6_iter",  64'(iter_cnt),  64'(0));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
